// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide, one bit per clock.
// Shift-add multiplier and restoring divider share one XLEN+2 adder.
// In : clk, rst_n (async, active low), start, funct3[2:0],
//      operand_a/operand_b[XLEN-1:0] (rs1/rs2 values)
// Out: busy (high in CALC), done (1-cycle pulse), result[XLEN-1:0]
// Build option: define MULDIV_FAST_EN to let zero operands, divide by
// zero and signed overflow skip CALC and finish one edge after start.
module mul_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state, nextState;

  logic [2:0]      op;
  logic            negQ;
  logic            negR;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] divisor;
  logic [CW-1:0]   cnt;

  logic            aSigned, bSigned;
  logic            aNeg, bNeg, bZero;
  logic [XLEN-1:0] aMag, bMag;

  always_comb begin
    aSigned = 1'b0;
    bSigned = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        aSigned = 1'b1;
        bSigned = 1'b1;
      end
      3'b010:  aSigned = 1'b1;
      default: ;
    endcase
  end

  assign aNeg  = aSigned & operand_a[XLEN-1];
  assign bNeg  = bSigned & operand_b[XLEN-1];
  assign bZero = (operand_b == '0);
  assign aMag  = aNeg ? -operand_a : operand_a;
  assign bMag  = bNeg ? -operand_b : operand_b;

`ifdef MULDIV_FAST_EN
  logic            aZero;
  logic            ovf;
  logic            fastHit;
  logic [XLEN-1:0] fastRes;

  assign aZero = (operand_a == '0);
  assign ovf = funct3[2] & ~funct3[0]
             & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
             & (&operand_b);
  assign fastHit = aZero | bZero | ovf;

  // Zero operand: products, quotients and remainders are all 0
  // except the divide-by-zero and DIV overflow cases below.
  always_comb begin
    fastRes = '0;
    if (funct3[2]) begin
      if (bZero) begin
        fastRes = funct3[1] ? operand_a : '1;
      end else if (ovf & ~funct3[1]) begin
        fastRes = operand_a;
      end
    end
  end
`endif

  // Shared adder: hi + divisor when multiplying,
  // {hi,next dividend bit} - divisor when dividing.
  logic            isDiv;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] addA, addB, sum;
  logic [XLEN:0]   mulAcc;
  logic            fits;
  logic [XLEN-1:0] nHi, nLo;

  assign isDiv   = op[2];
  assign shifted = {hi, lo[XLEN-1]};
  assign addA    = isDiv ? {1'b0, shifted} : {2'b00, hi};
  assign addB    = isDiv ? ~{2'b00, divisor} : {2'b00, divisor};
  assign sum     = addA + addB + {{(XLEN+1){1'b0}}, isDiv};
  assign mulAcc  = lo[0] ? sum[XLEN:0] : {1'b0, hi};
  assign fits    = ~sum[XLEN+1];

  assign nHi = isDiv ? (fits ? sum[XLEN-1:0] : shifted[XLEN-1:0])
                     : mulAcc[XLEN:1];
  assign nLo = isDiv ? {lo[XLEN-2:0], fits}
                     : {mulAcc[0], lo[XLEN-1:1]};

  // Sign fix-up of the final iteration's values.
  // A zero divisor never sets negQ, so the quotient stays all ones.
  logic [2*XLEN-1:0] prod, prodS;
  logic [XLEN-1:0]   quo, rem, finalRes;

  assign prod  = {nHi, nLo};
  assign prodS = negQ ? -prod : prod;
  assign quo   = negQ ? -nLo : nLo;
  assign rem   = negR ? -nHi : nHi;

  always_comb begin
    finalRes = '0;
    case (op)
      3'b000:                 finalRes = prodS[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalRes = prodS[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalRes = quo;
      default:                finalRes = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_EN
          nextState = fastHit ? DONE : CALC;
`else
          nextState = CALC;
`endif
        end
      end
      CALC:    if (cnt == LAST) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op      <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op      <= funct3;
            negQ    <= (aNeg ^ bNeg) & ~bZero;
            negR    <= aNeg;
            hi      <= '0;
            lo      <= aMag;
            divisor <= bMag;
            cnt     <= '0;
`ifdef MULDIV_FAST_EN
            if (fastHit) result <= fastRes;
`endif
          end
        end
        CALC: begin
          hi  <= nHi;
          lo  <= nLo;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) result <= finalRes;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table vectors, random model checks and
// hand-written abort / ignored-start sequences for mul_div_unit.
module tb_mul_div_unit;
  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
`ifdef MULDIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .funct3(funct3),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];
  logic [63:0] sb[$];
  int nCmp = 0;
  int nBad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(logic [2:0] f,
                                        logic [63:0] a,
                                        logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic signed [63:0] sa, sbv;
    logic ovf;
    ea  = (f == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
    eb  = (f == 3'b000 || f == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
    p   = ea * eb;
    sa  = a;
    sbv = b;
    ovf = (a == MINV) && (b == ONES);
    case (f)
      3'b000: return p[63:0];
      3'b001, 3'b010, 3'b011: return p[127:64];
      3'b100: return (b == 0) ? ONES : ovf ? a : 64'(sa / sbv);
      3'b101: return (b == 0) ? ONES : a / b;
      3'b110: return (b == 0) ? a : ovf ? 64'd0 : 64'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(logic [2:0] f, logic [63:0] a, logic [63:0] b);
    bit sp;
    sp = (a == 0) || (b == 0) ||
         (f[2] && !f[0] && a == MINV && b == ONES);
    return (FAST && sp) ? 0 : XLEN;
  endfunction

  task automatic issue(logic [2:0] f, logic [63:0] a,
                       logic [63:0] b, logic [63:0] exp);
    start     = 1'b1;
    funct3    = f;
    operand_a = a;
    operand_b = b;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(string name, int expLat, int k);
    int edges;
    int busyN;
    logic [63:0] exp;
    edges = k;
    busyN = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) busyN++;
      @(negedge clk);
      edges++;
    end
    if (done !== 1'b1) begin
      nCmp++;
      nBad++;
      $display("FAIL %s timeout: no done after %0d edges", name, edges);
    end
    chk({name, " latency"}, 64'(edges), 64'(expLat));
    chk({name, " busy"}, 64'(busyN), 64'(expLat - k));
    if (sb.size() == 0) begin
      nCmp++;
      nBad++;
      $display("FAIL %s: got done with empty scoreboard", name);
    end else begin
      exp = sb.pop_front();
      chk({name, " result"}, result, exp);
    end
    @(negedge clk);
    chk({name, " pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int nd;
    logic [2:0]  rf;
    logic [63:0] ra, rb;

    tbl[0]  = '{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1]  = '{3'b011, ONES, 64'd2, 64'd1};
    tbl[2]  = '{3'b001, ONES, 64'd2, ONES};
    tbl[3]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                64'hFFFF_FFFF_FFFF_FFFA};
    tbl[4]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                64'hFFFF_FFFF_FFFF_FFFE};
    tbl[5]  = '{3'b101, 64'd100, 64'd0, ONES};
    tbl[6]  = '{3'b111, 64'd100, 64'd0, 64'd100};
    tbl[7]  = '{3'b100, MINV, ONES, MINV};
    tbl[8]  = '{3'b110, MINV, ONES, 64'd0};
    tbl[9]  = '{3'b010, ONES, 64'd2, ONES};
    tbl[10] = '{3'b000, 64'd0, 64'd12345, 64'd0};
    tbl[11] = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, ONES};
    tbl[12] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
                64'hFFFF_FFFF_FFFF_FFF9};
    tbl[13] = '{3'b101, ONES, 64'd3, 64'h5555_5555_5555_5555};
    tbl[14] = '{3'b111, ONES, 64'd3, 64'd0};
    tbl[15] = '{3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[16] = '{3'b110, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2};
    tbl[17] = '{3'b100, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD,
                64'hFFFF_FFFF_FFFF_FFFA};
    tbl[18] = '{3'b100, 64'd0, 64'd9, 64'd0};

    rst_n     = 1'b0;
    start     = 1'b0;
    funct3    = 3'b000;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp);
      waitDone($sformatf("vec%0d", i), lat(tbl[i].f, tbl[i].a, tbl[i].b), 0);
    end

    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = (i == 3) ? 64'd0 : {$urandom, $urandom};
      issue(rf, ra, rb, model(rf, ra, rb));
      waitDone($sformatf("rnd%0d", i), lat(rf, ra, rb), 0);
    end

    // second start while busy must be ignored
    issue(3'b000, 64'd5, 64'd6, 64'd30);
    repeat (10) @(negedge clk);
    start     = 1'b1;
    operand_a = 64'd9;
    operand_b = 64'd9;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignored start", XLEN, 11);
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("ignored start extra done", 64'(nd), 64'd0);

    // reset in the middle of a divide
    issue(3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
          64'hFFFF_FFFF_FFFF_FFFA);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {63'b0, busy}, 64'd0);
    chk("abort done", {63'b0, done}, 64'd0);
    chk("abort result", result, 64'd0);
    void'(sb.pop_front());
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort no done", 64'(nd), 64'd0);
    issue(3'b000, 64'd4, 64'd4, 64'd16);
    waitDone("after abort", XLEN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
